// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
//
// Programmable, glitch-free clock divider. Produces a divided clock level
// (sclk) from clk together with single-cycle rise/fall strobes that logic
// staying on clk can use as clock enables. The divisor can be changed at run
// time; a new divisor is held pending and only takes over at a period
// boundary (wrap) or on a restart, so sclk never shows a runt phase.
//
// Phase shape for active divisor D: low phase L = D - floor(D/2) cycles,
// then high phase H = floor(D/2) cycles (odd D spends the extra cycle low).
//
// Parameters
//   CNT_W      width of divisor and counter (2..16)
//   RESET_DIV  divisor active after reset (0 and 1 are stored as 2)
//
// Ports
//   clk         in   source clock, rising edge
//   rst         in   asynchronous active-high reset
//   en          in   count enable; low freezes counter and sclk
//   clr         in   synchronous restart of the current period
//   div_in      in   requested divisor
//   div_load    in   strobe: capture div_in into the pending register
//   div_busy    out  a pending divisor is waiting for hand-over
//   div_active  out  divisor currently in use (after clamping)
//   sclk        out  divided clock level
//   tick_rise   out  pulse in the first cycle sclk is high
//   tick_fall   out  pulse in the first cycle sclk is low after a wrap
// ---------------------------------------------------------------------------
module clk_div_prog #(
  parameter int CNT_W     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  output logic [CNT_W-1:0] div_active,
  output logic             sclk,
  output logic             tick_rise,
  output logic             tick_fall
);

  // Divisors below 2 cannot form both a high and a low phase.
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  localparam logic [CNT_W-1:0] RESET_D =
    (RESET_DIV < 2) ? CNT_W'(2) : CNT_W'(RESET_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend;

  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W-1:0] cnt_n;
  logic             wrap;
  logic             handover;

  // Period boundaries always come from the active divisor. Because the
  // active divisor only changes when the counter restarts at 0, cnt can
  // never sit beyond the new last_cnt.
  always_comb begin
    last_cnt = div_active - CNT_W'(1);
    low_len  = div_active - (div_active >> 1);
    wrap     = (cnt == last_cnt);
    cnt_n    = wrap ? '0 : cnt + CNT_W'(1);
    // A pending divisor takes over on a counted wrap or on a restart; both
    // leave sclk low at cnt 0, which is what keeps the hand-over glitch-free.
    handover = clr | (en & wrap);
  end

  // Counter, divided clock level and tick strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      sclk      <= 1'b0;
      tick_rise <= 1'b0;
      tick_fall <= 1'b0;
    end else begin
      tick_rise <= 1'b0;
      tick_fall <= 1'b0;
      if (clr) begin
        cnt  <= '0;
        sclk <= 1'b0;
      end else if (en) begin
        cnt       <= cnt_n;
        sclk      <= (cnt_n >= low_len);
        tick_rise <= (cnt_n == low_len);
        tick_fall <= wrap;
      end
    end
  end

  // Divisor hand-over. When nothing is pending, pend already equals
  // div_active, so copying it across on every hand-over edge is harmless and
  // gives "the value pending before this cycle wins" for free when a load
  // lands on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_active <= RESET_D;
      pend       <= RESET_D;
      div_busy   <= 1'b0;
    end else begin
      if (handover) begin
        div_active <= pend;
      end
      if (div_load) begin
        pend     <= clamp_div(div_in);
        div_busy <= 1'b1;
      end else if (handover) begin
        div_busy <= 1'b0;
      end
    end
  end

endmodule
